// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the single-cycle cpu platform: the run-controller
//   state encoding (also exported on the debug 'state' port) and the default
//   instruction word width.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned STATE_W    = 3;

  // Encoding is visible on the debug port, so values are pinned explicitly.
  typedef enum logic [STATE_W-1:0] {
    ST_LOAD  = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } run_state_t;

endpackage

// File: rtl/run_watchdog.sv
// -----------------------------------------------------------------------------
// run_watchdog
//   Counts cycles the cpu actually runs, saturating at 2^32-1, and flags when
//   the count would reach MAX_CYCLES (0 disables the limit). The sticky
//   timeout flag is set only when the limit fires without a veto, so a halt
//   retiring in the same cycle wins over the watchdog.
// Ports
//   clock        in   1   rising-edge clock
//   reset_n      in   1   synchronous active-low reset
//   clear        in   1   zero the counter (start of a new run)
//   count_en     in   1   this is a run cycle: advance the counter
//   veto         in   1   suppress setting timeout this cycle (cpu halt)
//   cycle_count  out  32  run cycles counted so far
//   expire       out  1   this run cycle brings the count to the limit
//   timeout      out  1   sticky: limit fired without veto
// -----------------------------------------------------------------------------
module run_watchdog #(
  parameter int unsigned MAX_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        count_en,
  input  logic        veto,
  output logic [31:0] cycle_count,
  output logic        expire,
  output logic        timeout
);

  logic [31:0] count_inc;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (defaults first) so no latch can be inferred.
  always_comb begin
    count_inc = cycle_count;
    expire    = 1'b0;
    if (cycle_count != 32'hFFFF_FFFF) begin
      count_inc = cycle_count + 32'd1;
    end
    // Compare the post-increment value: the run cycle that makes the count
    // equal the limit is the last one allowed.
    if (count_en && (MAX_CYCLES != 32'd0) && (count_inc >= MAX_CYCLES)) begin
      expire = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cycle_count <= '0;
      timeout     <= 1'b0;
    end else begin
      if (clear) begin
        cycle_count <= '0;
      end else if (count_en) begin
        cycle_count <= count_inc;
      end
      if (expire && !veto) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//   Sequences the single-cycle cpu. After reset it accepts a program as a
//   valid/ready word stream and writes it into instruction memory with a
//   one-cycle registered write port. Once the last word (or a full memory)
//   is written the cpu is kept in reset until running_switch releases it.
//   While running, the switch pauses/resumes, a halt report ends the run and
//   the watchdog faults a run that exceeds MAX_CYCLES.
// Ports
//   clock, reset_n     clock and synchronous active-low reset
//   running_switch     1 = run/resume, 0 = pause (already synchronised)
//   ld_valid/ld_data/ld_last, ld_ready   program word stream
//   imem_we/imem_addr/imem_wdata         instruction memory write port
//   cpu_reset_n        low while loading or waiting to start
//   cpu_enable         high only while running
//   cpu_halt           cpu retired a halt instruction
//   state              current state (debug)
//   loaded_words       number of words written
//   cycle_count        run cycles since leaving READY
//   timeout            sticky watchdog flag
// -----------------------------------------------------------------------------
module cpu_run_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MAX_CYCLES = 1000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              running_switch,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset_n,
  output logic              cpu_enable,
  input  logic              cpu_halt,
  output logic [2:0]        state,
  output logic [ADDR_W:0]   loaded_words,
  output logic [31:0]       cycle_count,
  output logic              timeout
);

  run_state_t cur_state;
  run_state_t nxt_state;

  logic xfer;
  logic load_done;
  logic in_run;
  logic run_start;
  logic wd_expire;

  // ld_ready is a register that is only ever high in LOAD, so a transfer
  // cannot happen in any other state.
  assign xfer = ld_valid && ld_ready;

  // The word going to the top address fills the memory; loaded_words never
  // exceeds 2**ADDR_W, so the low bits alone identify that address.
  assign load_done = xfer && (ld_last || (loaded_words[ADDR_W-1:0] == {ADDR_W{1'b1}}));

  assign in_run    = (cur_state == ST_RUN);
  assign run_start = (cur_state == ST_READY) && running_switch;

  run_watchdog #(
    .MAX_CYCLES(MAX_CYCLES)
  ) u_watchdog (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (run_start),
    .count_en   (in_run),
    .veto       (cpu_halt),
    .cycle_count(cycle_count),
    .expire     (wd_expire),
    .timeout    (timeout)
  );

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_LOAD:  if (load_done) nxt_state = ST_READY;
      ST_READY: if (running_switch) nxt_state = ST_RUN;
      ST_RUN: begin
        // Halt beats the watchdog, which beats a pause request.
        if (cpu_halt) begin
          nxt_state = ST_DONE;
        end else if (wd_expire) begin
          nxt_state = ST_FAULT;
        end else if (!running_switch) begin
          nxt_state = ST_PAUSE;
        end
      end
      ST_PAUSE: if (running_switch) nxt_state = ST_RUN;
      ST_DONE, ST_FAULT: nxt_state = cur_state;
      default:  nxt_state = ST_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur_state    <= ST_LOAD;
      ld_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      loaded_words <= '0;
    end else begin
      cur_state <= nxt_state;
      // Registered so it stays low during reset and drops the cycle after
      // the final transfer.
      ld_ready  <= (nxt_state == ST_LOAD);
      imem_we   <= xfer;
      if (xfer) begin
        imem_addr    <= loaded_words[ADDR_W-1:0];
        imem_wdata   <= ld_data;
        loaded_words <= loaded_words + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  // DONE and FAULT keep the cpu out of reset so its state can be inspected.
  assign cpu_reset_n = (cur_state != ST_LOAD) && (cur_state != ST_READY);
  assign cpu_enable  = in_run;
  assign state       = cur_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  localparam int unsigned ADDR_W       = 8;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned MAX_CYCLES   = 1000;
  localparam int unsigned SMALL_ADDR_W = 2;

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset_n;
  logic              running_switch;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_reset_n;
  logic              cpu_enable;
  logic              cpu_halt;
  logic [2:0]        state;
  logic [ADDR_W:0]   loaded_words;
  logic [31:0]       cycle_count;
  logic              timeout;

  logic                    s_running_switch;
  logic                    s_ld_valid;
  logic [DATA_W-1:0]       s_ld_data;
  logic                    s_ld_last;
  logic                    s_ld_ready;
  logic                    s_imem_we;
  logic [SMALL_ADDR_W-1:0] s_imem_addr;
  logic [DATA_W-1:0]       s_imem_wdata;
  logic                    s_cpu_reset_n;
  logic                    s_cpu_enable;
  logic                    s_cpu_halt;
  logic [2:0]              s_state;
  logic [SMALL_ADDR_W:0]   s_loaded_words;
  logic [31:0]             s_cycle_count;
  logic                    s_timeout;

  cpu_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CYCLES(MAX_CYCLES)) dut (
    .clock(clock), .reset_n(reset_n), .running_switch(running_switch),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset_n(cpu_reset_n), .cpu_enable(cpu_enable), .cpu_halt(cpu_halt),
    .state(state), .loaded_words(loaded_words), .cycle_count(cycle_count),
    .timeout(timeout)
  );

  // Small memory, watchdog disabled.
  cpu_run_ctrl #(.ADDR_W(SMALL_ADDR_W), .DATA_W(DATA_W), .MAX_CYCLES(0)) dut_small (
    .clock(clock), .reset_n(reset_n), .running_switch(s_running_switch),
    .ld_valid(s_ld_valid), .ld_data(s_ld_data), .ld_last(s_ld_last), .ld_ready(s_ld_ready),
    .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
    .cpu_reset_n(s_cpu_reset_n), .cpu_enable(s_cpu_enable), .cpu_halt(s_cpu_halt),
    .state(s_state), .loaded_words(s_loaded_words), .cycle_count(s_cycle_count),
    .timeout(s_timeout)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- behavioural reference model (main DUT) ----------------
  logic [2:0]      m_state;
  bit              m_ready;
  bit              m_we;
  int unsigned     m_addr;
  logic [31:0]     m_wdata;
  int unsigned     m_loaded;
  longint unsigned m_cnt;
  bit              m_to;

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    m_we = 1'b0;
    if (!reset_n) begin
      m_state = S_LOAD; m_ready = 1'b0; m_addr = 0; m_wdata = '0;
      m_loaded = 0; m_cnt = 0; m_to = 1'b0;
      return;
    end
    case (m_state)
      S_LOAD: begin
        if (ld_valid && m_ready) begin
          m_we = 1'b1; m_addr = m_loaded; m_wdata = ld_data;
          m_loaded++;
          if (ld_last || m_loaded == (1 << ADDR_W)) m_state = S_READY;
        end
      end
      S_READY: if (running_switch) begin m_state = S_RUN; m_cnt = 0; end
      S_RUN: begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (cpu_halt) m_state = S_DONE;
        else if (MAX_CYCLES != 0 && m_cnt >= MAX_CYCLES) begin
          m_state = S_FAULT; m_to = 1'b1;
        end else if (!running_switch) m_state = S_PAUSE;
      end
      S_PAUSE: if (running_switch) m_state = S_RUN;
      default: ;
    endcase
    m_ready = (m_state == S_LOAD);
  endtask

  task automatic compare_model(input int cyc);
    string t;
    t = $sformatf("rnd%0d", cyc);
    check({t, ".state"}, state, m_state);
    check({t, ".ld_ready"}, ld_ready, m_ready);
    check({t, ".imem_we"}, imem_we, m_we);
    if (m_we) begin
      check({t, ".imem_addr"}, imem_addr, m_addr);
      check({t, ".imem_wdata"}, imem_wdata, m_wdata);
    end
    check({t, ".loaded_words"}, loaded_words, m_loaded);
    check({t, ".cpu_reset_n"}, cpu_reset_n, (m_state != S_LOAD && m_state != S_READY));
    check({t, ".cpu_enable"}, cpu_enable, (m_state == S_RUN));
    check({t, ".cycle_count"}, cycle_count, m_cnt);
    check({t, ".timeout"}, timeout, m_to);
  endtask

  // ---------------- directed helpers ----------------
  task automatic check_reset_values(input string t);
    check({t, ".state"}, state, S_LOAD);
    check({t, ".ld_ready"}, ld_ready, 0);
    check({t, ".imem_we"}, imem_we, 0);
    check({t, ".imem_addr"}, imem_addr, 0);
    check({t, ".imem_wdata"}, imem_wdata, 0);
    check({t, ".cpu_reset_n"}, cpu_reset_n, 0);
    check({t, ".cpu_enable"}, cpu_enable, 0);
    check({t, ".loaded_words"}, loaded_words, 0);
    check({t, ".cycle_count"}, cycle_count, 0);
    check({t, ".timeout"}, timeout, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; running_switch = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; cpu_halt = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1; ld_data = 32'h1000_0000 + i; ld_last = (i == n - 1);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  typedef struct {
    logic        valid;
    logic        last;
    logic [31:0] data;
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic        exp_ready;
    logic [2:0]  exp_state;
    logic [8:0]  exp_loaded;
  } ld_vec_t;

  ld_vec_t vecs [6];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int unsigned writes;
    int nwords;

    reset_n = 1'b0; running_switch = 1'b0; ld_valid = 1'b0; ld_data = '0;
    ld_last = 1'b0; cpu_halt = 1'b0;
    s_running_switch = 1'b0; s_ld_valid = 1'b0; s_ld_data = '0;
    s_ld_last = 1'b0; s_cpu_halt = 1'b0;

    // ---- reset values, ld_ready rises one cycle after release ----
    tick(); tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();
    check("reset.ld_ready_rise", ld_ready, 1);

    // ---- table-driven program load ----
    vecs[0] = '{1'b1, 1'b0, 32'h2008_0090, 1'b1, 8'd0, 1'b1, S_LOAD,  9'd1};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 8'd0, 1'b1, S_LOAD,  9'd1};
    vecs[2] = '{1'b1, 1'b0, 32'h2009_0091, 1'b1, 8'd1, 1'b1, S_LOAD,  9'd2};
    vecs[3] = '{1'b1, 1'b0, 32'h200A_0092, 1'b1, 8'd2, 1'b1, S_LOAD,  9'd3};
    vecs[4] = '{1'b1, 1'b1, 32'h200B_0093, 1'b1, 8'd3, 1'b0, S_READY, 9'd4};
    vecs[5] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 8'd0, 1'b0, S_READY, 9'd4};
    for (int i = 0; i < 6; i++) begin
      ld_valid = vecs[i].valid; ld_last = vecs[i].last; ld_data = vecs[i].data;
      tick();
      check($sformatf("vec%0d.imem_we", i), imem_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d.imem_addr", i), imem_addr, vecs[i].exp_addr);
        check($sformatf("vec%0d.imem_wdata", i), imem_wdata, vecs[i].data);
      end
      check($sformatf("vec%0d.ld_ready", i), ld_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d.state", i), state, vecs[i].exp_state);
      check($sformatf("vec%0d.loaded_words", i), loaded_words, vecs[i].exp_loaded);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("load.cpu_reset_n", cpu_reset_n, 0);

    // ---- READY waits, ignores halt; run 50 cycles then halt ----
    cpu_halt = 1'b1; tick(); cpu_halt = 1'b0; tick();
    check("ready.hold_state", state, S_READY);
    check("ready.cpu_enable", cpu_enable, 0);
    running_switch = 1'b1;
    tick();
    check("run.entered", state, S_RUN);
    check("run.count_cleared", cycle_count, 0);
    check("run.cpu_enable", cpu_enable, 1);
    repeat (49) tick();
    cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
    check("halt.state", state, S_DONE);
    check("halt.cycle_count", cycle_count, 50);
    check("halt.cpu_enable", cpu_enable, 0);
    check("halt.cpu_reset_n", cpu_reset_n, 1);
    check("halt.timeout", timeout, 0);
    running_switch = 1'b0; tick(); running_switch = 1'b1; tick(); tick();
    check("done.terminal_state", state, S_DONE);
    check("done.terminal_count", cycle_count, 50);

    // ---- small memory: 6 words without ld_last fill 4 slots ----
    writes = 0;
    for (int i = 0; i < 8; i++) begin
      s_ld_valid = (i < 6); s_ld_data = 32'hA000_0000 + i; s_ld_last = 1'b0;
      tick();
      if (s_imem_we) begin
        check($sformatf("full.addr%0d", writes), s_imem_addr, writes);
        check($sformatf("full.wdata%0d", writes), s_imem_wdata, 32'hA000_0000 + writes);
        writes++;
      end
      if (i == 3) begin
        check("full.ld_ready_after_4th", s_ld_ready, 0);
        check("full.state_after_4th", s_state, S_READY);
      end
    end
    s_ld_valid = 1'b0;
    check("full.write_count", writes, 4);
    check("full.loaded_words", s_loaded_words, 4);
    check("full.cpu_reset_n", s_cpu_reset_n, 0);

    // ---- watchdog disabled: run well past 1000 ----
    s_running_switch = 1'b1;
    tick();
    repeat (1004) tick();
    check("nowd.state", s_state, S_RUN);
    check("nowd.cycle_count", s_cycle_count, 1004);
    check("nowd.timeout", s_timeout, 0);
    check("nowd.cpu_enable", s_cpu_enable, 1);
    s_running_switch = 1'b0;

    // ---- pause / resume ----
    do_reset();
    load_prog(1);
    check("pause.ready", state, S_READY);
    running_switch = 1'b1;
    tick();
    begin
      logic rst_all_high;
      rst_all_high = cpu_reset_n;
      repeat (9) begin tick(); rst_all_high &= cpu_reset_n; end
      running_switch = 1'b0; tick(); rst_all_high &= cpu_reset_n;
      check("pause.enter_state", state, S_PAUSE);
      check("pause.enter_count", cycle_count, 10);
      repeat (19) begin tick(); rst_all_high &= cpu_reset_n; end
      check("pause.hold_state", state, S_PAUSE);
      check("pause.hold_count", cycle_count, 10);
      check("pause.cpu_enable", cpu_enable, 0);
      running_switch = 1'b1; tick(); rst_all_high &= cpu_reset_n;
      check("resume.state", state, S_RUN);
      repeat (5) begin tick(); rst_all_high &= cpu_reset_n; end
      check("resume.cycle_count", cycle_count, 15);
      check("pause.cpu_reset_n_high", rst_all_high, 1);
    end

    // ---- watchdog fault (continues the same run) ----
    for (int i = 0; i < 2000 && state == S_RUN; i++) tick();
    check("wd.state", state, S_FAULT);
    check("wd.cycle_count", cycle_count, 1000);
    check("wd.timeout", timeout, 1);
    check("wd.cpu_enable", cpu_enable, 0);
    check("wd.cpu_reset_n", cpu_reset_n, 1);
    cpu_halt = 1'b1; tick(); cpu_halt = 1'b0; tick();
    check("wd.terminal_state", state, S_FAULT);

    // ---- switch already high at READY; halt same cycle as watchdog ----
    do_reset();
    running_switch = 1'b1;
    load_prog(2);
    check("sw_high.ready", state, S_READY);
    tick();
    check("sw_high.run_next", state, S_RUN);
    repeat (999) tick();
    check("edge.state_999", state, S_RUN);
    check("edge.count_999", cycle_count, 999);
    cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
    check("haltwd.state", state, S_DONE);
    check("haltwd.cycle_count", cycle_count, 1000);
    check("haltwd.timeout", timeout, 0);

    // ---- reset mid-load and mid-run ----
    do_reset();
    ld_valid = 1'b1; ld_data = 32'h5555_0000; tick();
    ld_data = 32'h5555_0001; tick();
    reset_n = 1'b0; ld_valid = 1'b0;
    tick();
    check_reset_values("midload");
    reset_n = 1'b1; tick();
    load_prog(1);
    running_switch = 1'b1;
    repeat (6) tick();
    reset_n = 1'b0;
    tick();
    check_reset_values("midrun");
    running_switch = 1'b0;

    // ---- randomized episodes against the reference model ----
    for (int ep = 0; ep < 4; ep++) begin
      reset_n = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; running_switch = 1'b0; cpu_halt = 1'b0;
      model_step(); tick();
      model_step(); tick(); compare_model(-1);
      reset_n = 1'b1;
      nwords = $urandom_range(1, 12);
      for (int c = 0; c < 1600; c++) begin
        if (m_state == S_LOAD) begin
          ld_valid = ($urandom_range(0, 2) != 0);
          ld_last  = (m_loaded == nwords - 1);
        end else begin
          ld_valid = ($urandom_range(0, 7) == 0);
          ld_last  = $urandom_range(0, 1);
        end
        ld_data = $urandom();
        if (running_switch) begin
          if ($urandom_range(0, 39) == 0) running_switch = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          running_switch = 1'b1;
        end
        cpu_halt = (ep != 0) && ($urandom_range(0, 799) == 0);
        model_step();
        tick();
        compare_model(c);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
